// File: rtl/linebuf_nrow.sv
// rtl/linebuf_nrow.sv - parametrised N-row line buffer emitting vertical pixel columns
module linebuf_nrow #(
   parameter int NUM_LINES  = 3,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_LENGTH = 100,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic [DATA_WIDTH-1:0]           data_in,
   input  logic                            sof,
   input  logic [ADDR_WIDTH:0]             line_len,
   output logic [NUM_LINES*DATA_WIDTH-1:0] data_out,
   output logic                            out_valid,
   output logic [ADDR_WIDTH-1:0]           out_col,
   output logic                            out_eol,
   output logic                            primed
);

   // L stored lines; one memory per stored line, rotated by wr_row
   localparam int L    = NUM_LINES - 1;
   localparam int WR_W = (L > 1) ? $clog2(L) : 1;
   localparam int RF_W = $clog2(NUM_LINES);

   localparam logic [ADDR_WIDTH:0] MAX_LEN_V = (ADDR_WIDTH+1)'(MAX_LENGTH);
   localparam logic [RF_W-1:0]     RF_FULL   = RF_W'(L);
   localparam logic [WR_W-1:0]     WR_LAST   = WR_W'(L - 1);

   logic [DATA_WIDTH-1:0] mem [0:L-1][0:MAX_LENGTH-1];

   logic [ADDR_WIDTH-1:0] col;
   logic [WR_W-1:0]       wr_row;
   logic [RF_W-1:0]       rows_filled;
   logic [ADDR_WIDTH:0]   len_q;

   // State as seen by the current beat: a sof beat restarts the frame before it is processed
   logic [ADDR_WIDTH-1:0] col_eff;
   logic [WR_W-1:0]       wr_eff;
   logic [RF_W-1:0]       rf_eff;
   logic [ADDR_WIDTH:0]   len_eff;
   logic                  at_eol;

   // Memory holding the line k rows above the row currently being written
   function automatic logic [WR_W-1:0] src_row(input logic [WR_W-1:0] w, input int k);
      int t;
      t = int'(w) + L - k;
      if (t >= L) t = t - L;
      return t[WR_W-1:0];
   endfunction

   // Apply sof restart and line-length clamping to the beat's working state
   always_comb begin
      col_eff = col;
      wr_eff  = wr_row;
      rf_eff  = rows_filled;
      len_eff = len_q;
      if (in_valid && sof) begin
         col_eff = '0;
         wr_eff  = '0;
         rf_eff  = '0;
         if (line_len == '0 || line_len > MAX_LEN_V) len_eff = MAX_LEN_V;
         else                                        len_eff = line_len;
      end
      at_eol = ({1'b0, col_eff} == (len_eff - 1'b1));
   end

   // Line memories: written after the column read, so reads see the previous contents
   always_ff @(posedge clk) begin
      if (!rst && in_valid) mem[wr_eff][col_eff] <= data_in;
   end

   // Column output register and raster position tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         col         <= '0;
         wr_row      <= '0;
         rows_filled <= '0;
         len_q       <= MAX_LEN_V;
         data_out    <= '0;
         out_valid   <= 1'b0;
         out_col     <= '0;
         out_eol     <= 1'b0;
         primed      <= 1'b0;
      end else begin
         out_valid <= in_valid && (rf_eff == RF_FULL);
         if (in_valid) begin
            len_q <= len_eff;
            data_out[DATA_WIDTH-1:0] <= data_in;
            for (int k = 1; k <= L; k++) begin
               data_out[k*DATA_WIDTH +: DATA_WIDTH] <= mem[src_row(wr_eff, k)][col_eff];
            end
            out_col <= col_eff;
            out_eol <= at_eol;
            if (at_eol) begin
               col    <= '0;
               wr_row <= (wr_eff == WR_LAST) ? '0 : wr_eff + 1'b1;
               if (rf_eff != RF_FULL) rows_filled <= rf_eff + 1'b1;
               else                   rows_filled <= rf_eff;
               primed <= (rf_eff >= RF_FULL - 1'b1);
            end else begin
               col         <= col_eff + 1'b1;
               wr_row      <= wr_eff;
               rows_filled <= rf_eff;
               primed      <= (rf_eff == RF_FULL);
            end
         end
      end
   end

endmodule

// File: tb/tb_linebuf_nrow.sv
// tb/tb_linebuf_nrow.sv - self-checking bench for linebuf_nrow (3-row and 5-row instances)
module tb_linebuf_nrow;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v3, s3, v5, s5;
   logic [15:0] d3, d5;
   logic [7:0]  ll3, ll5;
   logic [47:0] do3;
   logic [79:0] do5;
   logic        ov3, oe3, pr3, ov5, oe5, pr5;
   logic [6:0]  oc3, oc5;

   linebuf_nrow #(.NUM_LINES(3), .DATA_WIDTH(16), .MAX_LENGTH(100), .ADDR_WIDTH(7)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .data_in(d3), .sof(s3), .line_len(ll3),
      .data_out(do3), .out_valid(ov3), .out_col(oc3), .out_eol(oe3), .primed(pr3));

   linebuf_nrow #(.NUM_LINES(5), .DATA_WIDTH(16), .MAX_LENGTH(100), .ADDR_WIDTH(7)) dut5 (
      .clk(clk), .rst(rst), .in_valid(v5), .data_in(d5), .sof(s5), .line_len(ll5),
      .data_out(do5), .out_valid(ov5), .out_col(oc5), .out_eol(oe5), .primed(pr5));

   int n_cmp = 0;
   int n_bad = 0;

   // Frame model: pixels stored by (frame row, column); a column is the same column in previous rows
   int   m_r [2];
   int   m_c [2];
   int   m_len [2];
   int   pix [2][16][128];
   logic exp_v [2], exp_e [2], exp_p [2], chk [2];
   logic live [2] = '{1'b0, 1'b0};
   int   exp_col [2];
   int   exp_d [2][5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input int i, input int nl, input logic r, input logic v,
                             input logic s, input int d, input int ll);
      if (r) begin
         m_r[i] = 0; m_c[i] = 0; m_len[i] = 100;
         exp_v[i] = 0; exp_e[i] = 0; exp_p[i] = 0; exp_col[i] = 0;
         for (int k = 0; k < 5; k++) exp_d[i][k] = 0;
         chk[i] = 1; live[i] = 1;
      end else if (live[i]) begin
         if (v) begin
            if (s) begin
               m_r[i] = 0; m_c[i] = 0;
               m_len[i] = (ll == 0 || ll > 100) ? 100 : ll;
            end
            pix[i][m_r[i] % 16][m_c[i]] = d;
            exp_v[i]   = (m_r[i] >= nl - 1);
            exp_col[i] = m_c[i];
            exp_e[i]   = (m_c[i] == m_len[i] - 1);
            if (exp_v[i])
               for (int k = 0; k < nl; k++) exp_d[i][k] = pix[i][(m_r[i] - k) % 16][m_c[i]];
            chk[i] = exp_v[i];
            if (exp_e[i]) begin m_c[i] = 0; m_r[i]++; end
            else m_c[i]++;
            exp_p[i] = (m_r[i] >= nl - 1);
         end else begin
            exp_v[i] = 0;
            chk[i]   = 0;
         end
      end
   endtask

   // Model advances on each rising edge from the same inputs the DUTs sample
   always @(posedge clk) begin
      model_step(0, 3, rst, v3, s3, int'(d3), int'(ll3));
      model_step(1, 5, rst, v5, s5, int'(d5), int'(ll5));
   end

   task automatic cmp_inst(input int i, input int nl, input logic ov, input logic oe,
                           input logic pr, input logic [6:0] oc, input logic [79:0] dat);
      check($sformatf("n%0d_valid", nl), 32'(ov), 32'(exp_v[i]));
      check($sformatf("n%0d_primed", nl), 32'(pr), 32'(exp_p[i]));
      if (chk[i]) begin
         check($sformatf("n%0d_col", nl), 32'(oc), 32'(exp_col[i]));
         check($sformatf("n%0d_eol", nl), 32'(oe), 32'(exp_e[i]));
         for (int k = 0; k < nl; k++)
            check($sformatf("n%0d_slice%0d", nl, k), 32'(dat[k*16 +: 16]), 32'(exp_d[i][k]));
      end
   endtask

   // Compare on the falling edge, away from the sampling edge
   always @(negedge clk) begin
      if (live[0]) cmp_inst(0, 3, ov3, oe3, pr3, oc3, {32'd0, do3});
      if (live[1]) cmp_inst(1, 5, ov5, oe5, pr5, oc5, do5);
   end

   function automatic logic [15:0] sl3(input int k);
      return do3[k*16 +: 16];
   endfunction

   function automatic logic [15:0] sl5(input int k);
      return do5[k*16 +: 16];
   endfunction

   task automatic beat(input int i, input logic v, input logic s, input int d, input int ll);
      v3 = 0; s3 = 0; v5 = 0; s5 = 0;
      if (i == 0) begin v3 = v; s3 = s; d3 = 16'(d); ll3 = 8'(ll); end
      else        begin v5 = v; s5 = s; d5 = 16'(d); ll5 = 8'(ll); end
      @(negedge clk);
   endtask

   initial begin
      rst = 1; v3 = 0; s3 = 0; d3 = 0; ll3 = 100; v5 = 0; s5 = 0; d5 = 0; ll5 = 10;
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", 32'(ov3), 0);
      check("rst_primed", 32'(pr3), 0);
      check("rst_data", do3[31:0], 0);
      rst = 0;

      // Continuous 3-row stream, 5 lines
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 100; c++) begin
            beat(0, 1, (r == 0 && c == 0), r * 128 + c, 100);
            if (r == 1 && c == 98) check("t1_primed_early", 32'(pr3), 0);
            if (r == 1 && c == 99) begin
               check("t1_row1_invalid", 32'(ov3), 0);
               check("t1_primed_set", 32'(pr3), 1);
            end
            if (r == 2 && c == 5) begin
               check("t1_s0", 32'(sl3(0)), 261);
               check("t1_s1", 32'(sl3(1)), 133);
               check("t1_s2", 32'(sl3(2)), 5);
               check("t1_col", 32'(oc3), 5);
            end
            if (r == 2 && c == 99) check("t1_eol", 32'(oe3), 1);
            if (r == 4 && c == 0) begin
               check("t1_rot_s0", 32'(sl3(0)), 512);
               check("t1_rot_s1", 32'(sl3(1)), 384);
               check("t1_rot_s2", 32'(sl3(2)), 256);
            end
         end

      // Same pattern with random idle cycles between beats
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 100; c++) begin
            if ($urandom_range(1, 0) == 1) beat(0, 0, 0, 0, 100);
            beat(0, 1, (r == 0 && c == 0), r * 128 + c + 7, 100);
            if (r == 2 && c == 50) begin
               check("t2_s0", 32'(sl3(0)), 313);
               check("t2_s2", 32'(sl3(2)), 57);
            end
         end

      // Restart at row 3 col 40 of a running frame
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 100; c++)
            if (r < 3 || c < 40) beat(0, 1, (r == 0 && c == 0), r * 128 + c, 100);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 100; c++) begin
            beat(0, 1, (r == 0 && c == 0), 1000 + r * 128 + c, 100);
            if (r == 1 && c == 99) check("t3_still_invalid", 32'(ov3), 0);
            if (r == 2 && c == 3) begin
               check("t3_s0", 32'(sl3(0)), 1259);
               check("t3_s1", 32'(sl3(1)), 1131);
               check("t3_s2", 32'(sl3(2)), 1003);
            end
         end

      // Reset in the middle of row 2, then restart with line_len=0
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 100; c++)
            if (r < 2 || c <= 10) beat(0, 1, (r == 0 && c == 0), r * 128 + c, 100);
      rst = 1;
      beat(0, 1, 0, 77, 100);
      rst = 0;
      check("t4_rst_valid", 32'(ov3), 0);
      check("t4_rst_col", 32'(oc3), 0);
      check("t4_rst_eol", 32'(oe3), 0);
      check("t4_rst_primed", 32'(pr3), 0);
      check("t4_rst_data", do3[31:0], 0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 100; c++) begin
            beat(0, 1, (r == 0 && c == 0), r * 128 + c, 0);
            if (r == 2 && c == 98) check("t4_eol_early", 32'(oe3), 0);
            if (r == 2 && c == 99) begin
               check("t4_eol_99", 32'(oe3), 1);
               check("t4_valid_99", 32'(ov3), 1);
            end
         end

      // 5-row instance, line_len=10; a line_len change on a non-sof beat must be ignored
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 10; c++) begin
            beat(1, 1, (r == 0 && c == 0), r * 16 + c, (r == 1 && c == 4) ? 3 : 10);
            if (r == 3 && c == 0) check("t5_row3_invalid", 32'(ov5), 0);
            if (r == 3 && c == 9) check("t5_primed", 32'(pr5), 1);
            if (r == 4 && c == 3) begin
               check("t5_s0", 32'(sl5(0)), 67);
               check("t5_s1", 32'(sl5(1)), 51);
               check("t5_s2", 32'(sl5(2)), 35);
               check("t5_s3", 32'(sl5(3)), 19);
               check("t5_s4", 32'(sl5(4)), 3);
            end
            if (r == 4 && c == 9) check("t5_eol", 32'(oe5), 1);
         end

      // line_len=1: every beat closes a line
      for (int n = 0; n < 7; n++) begin
         beat(1, 1, (n == 0), 500 + n, 1);
         if (n == 3) check("t6_invalid", 32'(ov5), 0);
         if (n == 4) begin
            check("t6_valid", 32'(ov5), 1);
            check("t6_eol", 32'(oe5), 1);
            check("t6_s0", 32'(sl5(0)), 504);
            check("t6_s4", 32'(sl5(4)), 500);
         end
      end

      beat(0, 0, 0, 0, 100);
      beat(0, 0, 0, 0, 100);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
